// File: rtl/dmem_arbiter.sv
// N-channel data-memory arbiter: fixed-priority or round-robin grant over val/rdy
// requesters, with a tag FIFO that routes in-order memory responses back to the
// channel that issued each request.
module dmem_arbiter #(
    parameter int unsigned NCH    = 2,
    parameter int unsigned AW     = 32,
    parameter int unsigned DW     = 32,
    parameter int unsigned MAXOUT = 4,
    parameter int unsigned RR     = 0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NCH-1:0]             req_val,
    output logic [NCH-1:0]             req_rdy,
    input  logic [NCH-1:0]             req_type,
    input  logic [NCH*AW-1:0]          req_addr,
    input  logic [NCH*DW-1:0]          req_wdata,
    output logic [NCH-1:0]             resp_val,
    output logic [DW-1:0]              resp_rdata,
    output logic                       mem_req_val,
    input  logic                       mem_req_rdy,
    output logic                       mem_req_type,
    output logic [AW-1:0]              mem_req_addr,
    output logic [DW-1:0]              mem_req_wdata,
    input  logic                       mem_resp_val,
    input  logic [DW-1:0]              mem_resp_rdata,
    output logic [$clog2(MAXOUT):0]    outstanding,
    output logic                       err
);

    localparam int unsigned TW = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int unsigned CW = $clog2(MAXOUT) + 1;
    localparam int unsigned PW = (MAXOUT > 1) ? $clog2(MAXOUT) : 1;

    logic [TW-1:0] ptr_q, ptr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
    logic          err_q, err_d;
    logic [TW-1:0] tag_q [MAXOUT];

    logic          gnt_any;
    logic [TW-1:0] gnt_idx;
    logic [TW-1:0] cand;
    logic          full;
    logic          push;
    logic          pop;

    // Grant search: first requesting channel starting at ptr (ptr stays 0 in fixed mode).
    always_comb begin
        gnt_any = 1'b0;
        gnt_idx = '0;
        cand    = '0;
        for (int k = 0; k < int'(NCH); k++) begin
            cand = TW'((int'(ptr_q) + k) % int'(NCH));
            if (!gnt_any && req_val[cand]) begin
                gnt_any = 1'b1;
                gnt_idx = cand;
            end
        end
    end

    // Request path, handshake and response routing; all combinational.
    always_comb begin
        full          = (cnt_q == CW'(MAXOUT));
        mem_req_val   = gnt_any & ~full & rst;
        push          = mem_req_val & mem_req_rdy;
        pop           = mem_resp_val & (cnt_q != '0) & rst;
        req_rdy       = push ? (NCH'(1) << gnt_idx) : '0;
        mem_req_type  = gnt_any ? req_type[gnt_idx] : 1'b0;
        mem_req_addr  = gnt_any ? req_addr[gnt_idx*AW +: AW] : '0;
        mem_req_wdata = gnt_any ? req_wdata[gnt_idx*DW +: DW] : '0;
        resp_val      = pop ? (NCH'(1) << tag_q[rd_q]) : '0;
        resp_rdata    = mem_resp_rdata;
        outstanding   = cnt_q;
        err           = err_q;
    end

    // Next-state for pointers, count and the sticky error flag.
    always_comb begin
        ptr_d = ptr_q;
        wr_d  = wr_q;
        rd_d  = rd_q;
        cnt_d = cnt_q;
        err_d = err_q | (mem_resp_val & (cnt_q == '0));
        if (push) begin
            wr_d = (wr_q == PW'(MAXOUT - 1)) ? '0 : wr_q + 1'b1;
            if (RR != 0) begin
                ptr_d = (gnt_idx == TW'(NCH - 1)) ? '0 : gnt_idx + 1'b1;
            end
        end
        if (pop) begin
            rd_d = (rd_q == PW'(MAXOUT - 1)) ? '0 : rd_q + 1'b1;
        end
        if (push && !pop) begin
            cnt_d = cnt_q + 1'b1;
        end else if (pop && !push) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    // Control state with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            ptr_q <= '0;
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            ptr_q <= ptr_d;
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end

    // Tag storage; contents are only meaningful between the read and write pointers.
    always_ff @(posedge clk) begin
        if (push) begin
            tag_q[wr_q] <= gnt_idx;
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench: a fixed-priority instance (MAXOUT=2) and a round-robin instance
// (MAXOUT=4), both 4 channels, driven by per-scenario tasks.
module tb_dmem_arbiter;

    logic clk;
    logic rst;

    logic [3:0]   f_req_val, f_req_rdy, f_req_type, f_resp_val;
    logic [127:0] f_req_addr, f_req_wdata;
    logic [31:0]  f_resp_rdata, f_mem_req_addr, f_mem_req_wdata, f_mem_resp_rdata;
    logic         f_mem_req_val, f_mem_req_rdy, f_mem_req_type, f_mem_resp_val, f_err;
    logic [1:0]   f_outstanding;

    logic [3:0]   r_req_val, r_req_rdy, r_req_type, r_resp_val;
    logic [127:0] r_req_addr, r_req_wdata;
    logic [31:0]  r_resp_rdata, r_mem_req_addr, r_mem_req_wdata, r_mem_resp_rdata;
    logic         r_mem_req_val, r_mem_req_rdy, r_mem_req_type, r_mem_resp_val, r_err;
    logic [2:0]   r_outstanding;

    int checks;
    int errors;

    dmem_arbiter #(.NCH(4), .AW(32), .DW(32), .MAXOUT(2), .RR(0)) u_fix (
        .clk(clk), .rst(rst),
        .req_val(f_req_val), .req_rdy(f_req_rdy), .req_type(f_req_type),
        .req_addr(f_req_addr), .req_wdata(f_req_wdata),
        .resp_val(f_resp_val), .resp_rdata(f_resp_rdata),
        .mem_req_val(f_mem_req_val), .mem_req_rdy(f_mem_req_rdy),
        .mem_req_type(f_mem_req_type), .mem_req_addr(f_mem_req_addr),
        .mem_req_wdata(f_mem_req_wdata),
        .mem_resp_val(f_mem_resp_val), .mem_resp_rdata(f_mem_resp_rdata),
        .outstanding(f_outstanding), .err(f_err)
    );

    dmem_arbiter #(.NCH(4), .AW(32), .DW(32), .MAXOUT(4), .RR(1)) u_rr (
        .clk(clk), .rst(rst),
        .req_val(r_req_val), .req_rdy(r_req_rdy), .req_type(r_req_type),
        .req_addr(r_req_addr), .req_wdata(r_req_wdata),
        .resp_val(r_resp_val), .resp_rdata(r_resp_rdata),
        .mem_req_val(r_mem_req_val), .mem_req_rdy(r_mem_req_rdy),
        .mem_req_type(r_mem_req_type), .mem_req_addr(r_mem_req_addr),
        .mem_req_wdata(r_mem_req_wdata),
        .mem_resp_val(r_mem_resp_val), .mem_resp_rdata(r_mem_resp_rdata),
        .outstanding(r_outstanding), .err(r_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic test_reset();
        rst = 1'b0;
        f_req_val = 4'hF;
        r_req_val = 4'hF;
        f_mem_req_rdy = 1'b1;
        r_mem_req_rdy = 1'b1;
        repeat (2) begin
            @(negedge clk); #1;
            checks++;
            if (f_req_rdy !== 4'b0000 || r_req_rdy !== 4'b0000) begin
                errors++;
                $display("FAIL reset_req_rdy: got fix=%b rr=%b want 0000", f_req_rdy, r_req_rdy);
            end
            checks++;
            if (f_mem_req_val !== 1'b0 || r_mem_req_val !== 1'b0) begin
                errors++;
                $display("FAIL reset_mem_req_val: got fix=%b rr=%b want 0", f_mem_req_val,
                         r_mem_req_val);
            end
            checks++;
            if (f_outstanding !== 2'd0 || r_outstanding !== 3'd0 || f_err !== 1'b0) begin
                errors++;
                $display("FAIL reset_state: got out=%0d/%0d err=%b want 0/0/0", f_outstanding,
                         r_outstanding, f_err);
            end
        end
        @(negedge clk);
        rst = 1'b1;
        #1;
        checks++;
        if (f_req_rdy !== 4'b0001 || r_req_rdy !== 4'b0001) begin
            errors++;
            $display("FAIL reset_release_grant: got fix=%b rr=%b want 0001", f_req_rdy, r_req_rdy);
        end
        f_req_val = 4'h0;
        r_req_val = 4'h0;
        f_mem_req_rdy = 1'b0;
        r_mem_req_rdy = 1'b0;
    endtask

    task automatic test_fixed_priority();
        @(negedge clk);
        f_req_val = 4'b0011;
        f_req_type = 4'b0010;
        f_req_addr[31:0] = 32'h100;
        f_req_addr[63:32] = 32'h200;
        f_req_wdata[63:32] = 32'hDEAD;
        f_mem_req_rdy = 1'b1;
        #1;
        checks++;
        if (f_req_rdy !== 4'b0001 || f_mem_req_addr !== 32'h100 || f_mem_req_type !== 1'b0) begin
            errors++;
            $display("FAIL fixed_first: got rdy=%b addr=%h type=%b want 0001 100 0", f_req_rdy,
                     f_mem_req_addr, f_mem_req_type);
        end
        @(negedge clk);
        f_req_val = 4'b0010;
        #1;
        checks++;
        if (f_req_rdy !== 4'b0010 || f_mem_req_addr !== 32'h200 || f_mem_req_type !== 1'b1 ||
            f_mem_req_wdata !== 32'hDEAD || f_outstanding !== 2'd1) begin
            errors++;
            $display("FAIL fixed_second: got rdy=%b addr=%h type=%b wd=%h out=%0d want 0010 200 1 dead 1",
                     f_req_rdy, f_mem_req_addr, f_mem_req_type, f_mem_req_wdata, f_outstanding);
        end
        @(negedge clk);
        f_req_val = 4'b0000;
        f_mem_req_rdy = 1'b0;
        f_mem_resp_val = 1'b1;
        f_mem_resp_rdata = 32'hA5A5_0001;
        #1;
        checks++;
        if (f_resp_val !== 4'b0001 || f_resp_rdata !== 32'hA5A5_0001 || f_outstanding !== 2'd2) begin
            errors++;
            $display("FAIL fixed_resp0: got resp=%b data=%h out=%0d want 0001 a5a50001 2",
                     f_resp_val, f_resp_rdata, f_outstanding);
        end
        @(negedge clk);
        f_mem_resp_rdata = 32'h0;
        #1;
        checks++;
        if (f_resp_val !== 4'b0010) begin
            errors++;
            $display("FAIL fixed_resp1: got resp=%b want 0010", f_resp_val);
        end
        @(negedge clk);
        f_mem_resp_val = 1'b0;
        #1;
        checks++;
        if (f_outstanding !== 2'd0 || f_resp_val !== 4'b0000) begin
            errors++;
            $display("FAIL fixed_drain: got out=%0d resp=%b want 0 0000", f_outstanding, f_resp_val);
        end
    endtask

    task automatic test_full();
        @(negedge clk);
        f_req_val = 4'b0001;
        f_req_type = 4'b0000;
        f_req_addr[31:0] = 32'h300;
        f_mem_req_rdy = 1'b1;
        #1;
        checks++;
        if (f_req_rdy !== 4'b0001) begin
            errors++;
            $display("FAIL full_acc0: got rdy=%b want 0001", f_req_rdy);
        end
        @(negedge clk); #1;
        checks++;
        if (f_req_rdy !== 4'b0001 || f_outstanding !== 2'd1) begin
            errors++;
            $display("FAIL full_acc1: got rdy=%b out=%0d want 0001 1", f_req_rdy, f_outstanding);
        end
        @(negedge clk); #1;
        checks++;
        if (f_mem_req_val !== 1'b0 || f_req_rdy !== 4'b0000 || f_outstanding !== 2'd2) begin
            errors++;
            $display("FAIL full_block: got mval=%b rdy=%b out=%0d want 0 0000 2", f_mem_req_val,
                     f_req_rdy, f_outstanding);
        end
        @(negedge clk);
        f_mem_resp_val = 1'b1;
        #1;
        checks++;
        if (f_resp_val !== 4'b0001 || f_mem_req_val !== 1'b0) begin
            errors++;
            $display("FAIL full_resp: got resp=%b mval=%b want 0001 0", f_resp_val, f_mem_req_val);
        end
        @(negedge clk); #1;
        checks++;
        if (f_outstanding !== 2'd1 || f_req_rdy !== 4'b0001 || f_resp_val !== 4'b0001) begin
            errors++;
            $display("FAIL full_reopen: got out=%0d rdy=%b resp=%b want 1 0001 0001", f_outstanding,
                     f_req_rdy, f_resp_val);
        end
        @(negedge clk);
        f_req_val = 4'b0000;
        #1;
        checks++;
        if (f_outstanding !== 2'd1) begin
            errors++;
            $display("FAIL full_pushpop: got out=%0d want 1", f_outstanding);
        end
        @(negedge clk);
        f_mem_resp_val = 1'b0;
        #1;
        checks++;
        if (f_outstanding !== 2'd0 || f_err !== 1'b0) begin
            errors++;
            $display("FAIL full_drain: got out=%0d err=%b want 0 0", f_outstanding, f_err);
        end
    endtask

    task automatic test_round_robin();
        int exp_g [10] = '{0, 1, 2, 3, 0, 1, 2, 3, 0, 2};
        r_mem_req_rdy = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            r_req_val = (i < 6) ? 4'b1111 : 4'b1101;
            r_mem_resp_val = (i > 0);
            r_mem_resp_rdata = 32'(i);
            #1;
            checks++;
            if (r_req_rdy !== (4'b0001 << exp_g[i])) begin
                errors++;
                $display("FAIL rr_grant[%0d]: got rdy=%b want ch%0d", i, r_req_rdy, exp_g[i]);
            end
            if (i > 0) begin
                checks++;
                if (r_resp_val !== (4'b0001 << exp_g[i-1]) || r_outstanding !== 3'd1) begin
                    errors++;
                    $display("FAIL rr_resp[%0d]: got resp=%b out=%0d want ch%0d 1", i, r_resp_val,
                             r_outstanding, exp_g[i-1]);
                end
            end
        end
        @(negedge clk);
        r_req_val = 4'b0000;
        r_mem_resp_val = 1'b1;
        #1;
        checks++;
        if (r_resp_val !== 4'b0100) begin
            errors++;
            $display("FAIL rr_last_resp: got resp=%b want 0100", r_resp_val);
        end
        @(negedge clk);
        r_mem_resp_val = 1'b0;
        #1;
        checks++;
        if (r_outstanding !== 3'd0) begin
            errors++;
            $display("FAIL rr_drain: got out=%0d want 0", r_outstanding);
        end
    endtask

    task automatic test_ordering();
        int ch [3] = '{2, 0, 1};
        r_mem_req_rdy = 1'b1;
        r_req_type = 4'b0000;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            r_req_val = 4'b0001 << ch[i];
            r_req_addr[ch[i]*32 +: 32] = 32'h40 + 32'(i * 4);
            #1;
            checks++;
            if (r_req_rdy !== (4'b0001 << ch[i]) || r_mem_req_addr !== 32'h40 + 32'(i * 4)) begin
                errors++;
                $display("FAIL ord_req[%0d]: got rdy=%b addr=%h want ch%0d %h", i, r_req_rdy,
                         r_mem_req_addr, ch[i], 32'h40 + 32'(i * 4));
            end
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            r_req_val = 4'b0000;
            r_mem_resp_val = 1'b1;
            r_mem_resp_rdata = 32'hD000_0000 + 32'(i);
            #1;
            checks++;
            if (r_resp_val !== (4'b0001 << ch[i]) || r_resp_rdata !== 32'hD000_0000 + 32'(i) ||
                r_outstanding !== 3'(3 - i)) begin
                errors++;
                $display("FAIL ord_resp[%0d]: got resp=%b data=%h out=%0d want ch%0d %h %0d", i,
                         r_resp_val, r_resp_rdata, r_outstanding, ch[i], 32'hD000_0000 + 32'(i),
                         3 - i);
            end
        end
        @(negedge clk);
        r_mem_resp_val = 1'b0;
        #1;
        checks++;
        if (r_outstanding !== 3'd0 || r_err !== 1'b0) begin
            errors++;
            $display("FAIL ord_drain: got out=%0d err=%b want 0 0", r_outstanding, r_err);
        end
    endtask

    task automatic test_error();
        @(negedge clk);
        f_mem_resp_val = 1'b1;
        #1;
        checks++;
        if (f_resp_val !== 4'b0000) begin
            errors++;
            $display("FAIL err_resp_val: got resp=%b want 0000", f_resp_val);
        end
        @(negedge clk);
        f_mem_resp_val = 1'b0;
        #1;
        checks++;
        if (f_err !== 1'b1) begin
            errors++;
            $display("FAIL err_set: got err=%b want 1", f_err);
        end
        repeat (10) @(negedge clk);
        #1;
        checks++;
        if (f_err !== 1'b1 || r_err !== 1'b0) begin
            errors++;
            $display("FAIL err_sticky: got fix=%b rr=%b want 1 0", f_err, r_err);
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        #1;
        checks++;
        if (f_err !== 1'b0) begin
            errors++;
            $display("FAIL err_clear: got err=%b want 0", f_err);
        end
        rst = 1'b1;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b0;
        f_req_val = '0; f_req_type = '0; f_req_addr = '0; f_req_wdata = '0;
        f_mem_req_rdy = 1'b0; f_mem_resp_val = 1'b0; f_mem_resp_rdata = '0;
        r_req_val = '0; r_req_type = '0; r_req_addr = '0; r_req_wdata = '0;
        r_mem_req_rdy = 1'b0; r_mem_resp_val = 1'b0; r_mem_resp_rdata = '0;
        test_reset();
        test_fixed_priority();
        test_full();
        test_round_robin();
        test_ordering();
        test_error();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Parametrised N-channel data-memory arbiter between the processor's requesters (pipeline M-stage, external test/loader port, future DMA/I/O masters) and the single data-memory port of the processor memory. It replaces hard-wired two-way request muxing with val/rdy handshakes, selectable fixed-priority or round-robin arbitration, and multiple outstanding requests. In-order responses are routed back to the originating channel through an internal tag FIFO.

## Interface
Parameters:
- NCH, 2, number of requester channels (2..8); channel 0 is the processor pipeline.
- AW, 32, address width.
- DW, 32, data width.
- MAXOUT, 4, maximum outstanding requests, i.e. tag FIFO depth (power of two, 1..16).
- RR, 0, 0 = fixed priority (lowest index wins), 1 = round-robin.

Ports:
- clk  in  1  clock, all state on rising edge.
- rst  in  1  reset, synchronous, active-low; state cleared on a rising clk edge while rst=0.
- req_val  in  NCH  per-channel request valid.
- req_rdy  out  NCH  per-channel request accepted this cycle.
- req_type  in  NCH  per channel: 0 = read, 1 = write.
- req_addr  in  NCH*AW  channel i in bits [i*AW +: AW].
- req_wdata  in  NCH*DW  channel i in bits [i*DW +: DW].
- resp_val  out  NCH  one-hot response valid for the owning channel.
- resp_rdata  out  DW  response data, shared by all channels.
- mem_req_val  out  1  request to memory.
- mem_req_rdy  in  1  memory accepts.
- mem_req_type / mem_req_addr / mem_req_wdata  out  1/AW/DW  selected channel's request.
- mem_resp_val  in  1  memory response, in request order.
- mem_resp_rdata  in  DW  response data; ack-only for writes.
- outstanding  out  clog2(MAXOUT)+1  number of in-flight requests.
- err  out  1  sticky: a response arrived while no request was outstanding.

## Operation
- Eligible set: channels with req_val=1. Grant is one-hot over the eligible set:
  - RR=0: lowest index wins.
  - RR=1: first eligible index at or after pointer ptr, wrapping NCH-1 -> 0.
- full = (outstanding == MAXOUT), computed from the registered count only.
- mem_req_val = any eligible & ~full & rst. mem_req_* carry the granted channel's fields; when there is no grant they are 0.
- req_rdy[i] = grant[i] & mem_req_rdy & ~full & rst. At most one bit is set.
- Transfer: mem_req_val & mem_req_rdy.
  - The granted index is pushed as a tag into the FIFO.
  - RR=1: ptr <= (granted + 1) mod NCH.
  - RR=0: ptr is unused and stays 0.
- Response: on mem_resp_val with FIFO non-empty:
  - Pop the head tag.
  - resp_val[tag] = 1; resp_rdata = mem_resp_rdata.
- Response on an empty FIFO:
  - resp_val stays all zero.
  - err <= 1, held until reset.
- Transfer and response in the same cycle: push and pop both occur and outstanding is unchanged. This holds even when the count equals MAXOUT-1 or 0, provided the response is legal.
- A requester holds val/type/addr/wdata stable until its req_rdy is set. The arbiter may switch its grant to a higher-priority channel while another channel waits (fixed mode has no starvation protection).
- Requests use the same data path for reads and writes. Every accepted request, write or read, produces exactly one response.

## Timing
- Request path is combinational: req_val -> mem_req_val/req_rdy in the same cycle, with zero added latency.
- Response routing is combinational: mem_resp_val -> resp_val in the same cycle.
- Memory must respond no earlier than the cycle after acceptance, so a request accepted at cycle t responds at cycle t+1 or later.
- outstanding, ptr, FIFO and err update on the rising edge after the event.
- When rst=0 at an edge, all of the following take effect on that edge, including mid-transaction:
  - ptr = 0, FIFO empty, outstanding = 0, err = 0.
  - Responses still in flight from memory are dropped by the owning environment; if they arrive after reset they set err.
- While rst=0, outputs are forced: req_rdy = 0, mem_req_val = 0, resp_val = 0.
- Throughput: one request per cycle while not full. With MAXOUT=1, throughput is one request per 2 cycles for 1-cycle memory unless the response and the new request coincide, which is permitted.

## Test plan
- Reset: hold rst=0 for 2 cycles with all req_val=1 -> req_rdy=0, mem_req_val=0, outstanding=0, err=0; release -> channel 0 granted in the first cycle.
- Fixed priority, NCH=2, RR=0: ch0 read 0x100 and ch1 write 0x200/0xDEAD both valid -> ch0 accepted first, then ch1. Responses: resp_val=01 with memory data, then resp_val=10.
- Round-robin, NCH=4, RR=1: all four channels valid continuously -> grant order 0,1,2,3,0,1. Drop ch1 -> order 2,3,0,2.
- Backpressure/full, MAXOUT=2: memory withholds responses -> 2 accepts, then mem_req_val=0 and outstanding=2. One response -> the next request is accepted the following cycle. A simultaneous response and request at count 1 keeps outstanding=1.
- Ordering: 3 reads from ch2, ch0, ch1 with 3-cycle memory latency -> resp_val sequence 100, 001, 010 with matching data.
- Error: mem_resp_val pulse with nothing outstanding -> err=1 and resp_val=0; err is still 1 ten cycles later and clears only after rst=0.
